// File: rtl/gf128_pkg.sv
// Shared GF(2^128) constants for the GHASH field (GCM bit-reflected order) and
// the state encoding used by the iterative inverter.
package gf128_pkg;

  localparam int NB_GF128 = 128;

  // Reduction constant: x^128 = x^7 + x^2 + x + 1, written in reflected order.
  localparam logic [NB_GF128-1:0] GF128_R_X = {8'he1, 120'd0};
  localparam logic [NB_GF128-1:0] GF128_ONE = {1'b1, {(NB_GF128-1){1'b0}}};

  localparam int GF128_INV_STEPS = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQR  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } inv_state_t;

endpackage

// File: rtl/gf_2to128_multiplier.sv
// Combinational GF(2^128) multiplier, GCM bit order: shift-and-add over the bits
// of x (x^0 first), shifting y by one power of the field element each step.
module gf_2to128_multiplier
  import gf128_pkg::*;
#(
  parameter int NB_DATA = NB_GF128
) (
  output logic [NB_DATA-1:0] o_data_z,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic [NB_DATA-1:0] i_data_y
);

  localparam logic [NB_DATA-1:0] R_X = NB_DATA'(GF128_R_X);

  logic [NB_DATA-1:0] z_acc [NB_DATA+1];
  logic [NB_DATA-1:0] v_acc [NB_DATA];

  assign z_acc[0] = '0;
  assign v_acc[0] = i_data_y;

  genvar gi;
  generate
    for (gi = 0; gi < NB_DATA; gi++) begin : g_step
      assign z_acc[gi+1] = i_data_x[NB_DATA-1-gi] ? (z_acc[gi] ^ v_acc[gi]) : z_acc[gi];
      // Multiply v by x: shift toward higher powers, fold x^128 back via R_X.
      if (gi < NB_DATA-1) begin : g_shift
        assign v_acc[gi+1] = v_acc[gi][0] ? ((v_acc[gi] >> 1) ^ R_X) : (v_acc[gi] >> 1);
      end
    end
  endgenerate

  assign o_data_z = z_acc[NB_DATA];

endmodule

// File: rtl/gf_2to128_inverter.sv
// Iterative GF(2^128) inverter: x^-1 = prod_{i=1..127} x^(2^i), computed by
// alternating square and multiply steps on one shared combinational multiplier.
module gf_2to128_inverter
  import gf128_pkg::*;
#(
  parameter int NB_DATA = NB_GF128
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data_x,
  output logic               o_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data_z,
  output logic               o_div_zero
);

  // Any width other than the GHASH field leaves the block permanently not-ready.
  localparam logic BAD_CONF = (NB_DATA != NB_GF128);
  localparam logic [NB_DATA-1:0] ONE = {1'b1, {(NB_DATA-1){1'b0}}};
  localparam logic [6:0] LAST_CNT = 7'(GF128_INV_STEPS - 1);

  inv_state_t state_reg;
  inv_state_t state_next;

  logic [NB_DATA-1:0] s_reg;
  logic [NB_DATA-1:0] r_reg;
  logic [NB_DATA-1:0] out_z_reg;
  logic [6:0]         cnt_reg;
  logic               pending_dz_reg;
  logic               out_dz_reg;

  logic [NB_DATA-1:0] mult_a;
  logic [NB_DATA-1:0] mult_b;
  logic [NB_DATA-1:0] mult_p;
  logic               accept;
  logic               last_step;

  assign accept    = o_ready && i_valid;
  assign last_step = (cnt_reg == LAST_CNT);

  assign mult_a = (state_reg == ST_SQR) ? s_reg : r_reg;
  assign mult_b = s_reg;

  gf_2to128_multiplier #(
    .NB_DATA (NB_DATA)
  ) u_mult (
    .o_data_z (mult_p),
    .i_data_x (mult_a),
    .i_data_y (mult_b)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_SQR;
      ST_SQR:  state_next = ST_MUL;
      ST_MUL:  state_next = last_step ? ST_DONE : ST_SQR;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_reg)
      ST_IDLE: o_ready = !BAD_CONF;
      ST_DONE: o_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s_reg          <= '0;
      r_reg          <= '0;
      cnt_reg        <= '0;
      pending_dz_reg <= 1'b0;
      out_z_reg      <= '0;
      out_dz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            s_reg          <= i_data_x;
            r_reg          <= ONE;
            cnt_reg        <= '0;
            pending_dz_reg <= (i_data_x == '0);
          end
        end
        ST_SQR: s_reg <= mult_p;
        ST_MUL: begin
          r_reg   <= mult_p;
          cnt_reg <= cnt_reg + 7'd1;
          if (last_step) begin
            out_z_reg  <= mult_p;
            out_dz_reg <= pending_dz_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data_z   = out_z_reg;
  assign o_div_zero = out_dz_reg;

endmodule

// File: tb/tb_gf_2to128_inverter.sv
// Directed bench for gf_2to128_inverter: known inverses, zero input, latency,
// back-to-back throughput with random elements, and a mid-computation reset.
module tb_gf_2to128_inverter;

  localparam logic [127:0] ONE_C   = {1'b1, 127'd0};
  localparam logic [127:0] X_C     = {2'b01, 126'd0};
  localparam logic [127:0] XINV_C  = 128'hC200_0000_0000_0000_0000_0000_0000_0001;

  logic         i_clock;
  logic         i_reset;
  logic         i_valid;
  logic [127:0] i_data_x;
  logic         o_ready;
  logic         o_valid;
  logic [127:0] o_data_z;
  logic         o_div_zero;

  int n_checks;
  int n_pass;

  gf_2to128_inverter #(
    .NB_DATA (128)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_data_x   (i_data_x),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_z   (o_data_z),
    .o_div_zero (o_div_zero)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Reference: plain polynomial product in normal bit order, then reduction.
  function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p;
    logic [127:0] r;
    p = '0;
    for (int i = 0; i < 128; i++) begin
      if (a[127-i]) begin
        for (int j = 0; j < 128; j++) begin
          if (b[127-j]) p[i+j] = ~p[i+j];
        end
      end
    end
    for (int k = 254; k >= 128; k--) begin
      if (p[k]) begin
        p[k]     = 1'b0;
        p[k-121] = ~p[k-121];
        p[k-126] = ~p[k-126];
        p[k-127] = ~p[k-127];
        p[k-128] = ~p[k-128];
      end
    end
    for (int k = 0; k < 128; k++) r[127-k] = p[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge with o_ready=1; returns at the negedge where o_valid is seen.
  task automatic do_inv(input logic [127:0] x, input bit hold_valid,
                        output logic [127:0] z, output logic dz, output int lat,
                        output bit ready_ok, output time t_acc);
    i_valid  = 1'b1;
    i_data_x = x;
    @(posedge i_clock);
    t_acc = $time;
    @(negedge i_clock);
    if (!hold_valid) i_valid = 1'b0;
    i_data_x = ~x ^ 128'h1234_5678;
    lat      = 0;
    ready_ok = 1'b1;
    while (!o_valid && lat < 400) begin
      if (o_ready) ready_ok = 1'b0;
      @(negedge i_clock);
      lat++;
    end
    z  = o_data_z;
    dz = o_div_zero;
    $display("inv x=%h z=%h dz=%0d latency=%0d", x, z, dz, lat);
  endtask

  initial begin
    logic [127:0] z, x;
    logic         dz;
    int           lat;
    bit           rdy_ok;
    bit           saw_valid;
    time          t_acc, t_prev;

    n_checks = 0;
    n_pass   = 0;
    i_reset  = 1'b1;
    i_valid  = 1'b0;
    i_data_x = '0;
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("reset_ready", 128'(o_ready), 128'd1);
    chk("reset_valid", 128'(o_valid), 128'd0);
    chk("reset_z", o_data_z, 128'd0);
    chk("reset_dz", 128'(o_div_zero), 128'd0);

    do_inv(ONE_C, 1'b0, z, dz, lat, rdy_ok, t_acc);
    chk("one_z", z, ONE_C);
    chk("one_dz", 128'(dz), 128'd0);
    chk("one_latency", 128'(lat), 128'd254);
    chk("one_busy", 128'(rdy_ok), 128'd1);
    @(negedge i_clock);
    chk("one_pulse", 128'(o_valid), 128'd0);
    chk("one_idle_ready", 128'(o_ready), 128'd1);
    chk("one_hold_z", o_data_z, ONE_C);

    do_inv(X_C, 1'b0, z, dz, lat, rdy_ok, t_acc);
    chk("x_z", z, XINV_C);
    chk("x_dz", 128'(dz), 128'd0);
    @(negedge i_clock);

    do_inv(XINV_C, 1'b0, z, dz, lat, rdy_ok, t_acc);
    chk("xinv_z", z, X_C);
    @(negedge i_clock);

    do_inv(128'd0, 1'b0, z, dz, lat, rdy_ok, t_acc);
    chk("zero_z", z, 128'd0);
    chk("zero_dz", 128'(dz), 128'd1);
    chk("zero_latency", 128'(lat), 128'd254);
    @(negedge i_clock);
    chk("zero_pulse", 128'(o_valid), 128'd0);
    chk("zero_hold_dz", 128'(o_div_zero), 128'd1);

    // Back-to-back with i_valid held high: one accept every 256 cycles.
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      do_inv(x, (i < 5), z, dz, lat, rdy_ok, t_acc);
      chk("rand_product", ref_mul(x, z), ONE_C);
      chk("rand_dz", 128'(dz), 128'd0);
      chk("rand_busy", 128'(rdy_ok), 128'd1);
      if (i > 0) chk("rand_interval", 128'((t_acc - t_prev) / 10), 128'd256);
      t_prev = t_acc;
      @(negedge i_clock);
      chk("rand_pulse", 128'(o_valid), 128'd0);
    end

    // Reset during SQR step 60 of a computation.
    x = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    i_valid  = 1'b1;
    i_data_x = x;
    @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    repeat (118) @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    chk("mid_reset_ready", 128'(o_ready), 128'd1);
    chk("mid_reset_valid", 128'(o_valid), 128'd0);
    chk("mid_reset_z", o_data_z, 128'd0);
    chk("mid_reset_dz", 128'(o_div_zero), 128'd0);
    saw_valid = 1'b0;
    repeat (300) begin
      @(negedge i_clock);
      if (o_valid) saw_valid = 1'b1;
    end
    chk("mid_reset_no_valid", 128'(saw_valid), 128'd0);
    do_inv(X_C, 1'b0, z, dz, lat, rdy_ok, t_acc);
    chk("post_reset_z", z, XINV_C);
    chk("post_reset_latency", 128'(lat), 128'd254);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
